// File: rtl/nanorv32_trace_serializer.sv
// rtl/nanorv32_trace_serializer.sv - retired-instruction trace capture FIFO and 34-byte ASCII line serializer
module nanorv32_trace_serializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          trace_valid,
    input  logic [31:0]                   trace_pc,
    input  logic [79:0]                   ascii_chain,
    input  logic [31:0]                   reg_to_ascii_rd,
    input  logic                          rd_wr_en,
    input  logic [31:0]                   rd_wdata,
    output logic [7:0]                    tx_byte,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DROP_CNT_W-1:0]         drop_cnt,
    output logic                          busy
);

    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int LW    = PW + 1;
    localparam int REC_W = 177;
    localparam logic [5:0] LAST_IDX = 6'd33;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         idx_q, idx_d;
    logic [LW-1:0]      level_q;
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [REC_W-1:0]   mem [FIFO_DEPTH];
    logic [REC_W-1:0]   rec_q;
    logic [DROP_CNT_W-1:0] drop_q;

    logic push_req, full, empty, push, drop, pop;

    // Record layout: {pc, mnemonic, rd name, rd_wr_en, wdata}
    logic [31:0] rec_pc;
    logic [79:0] rec_mn;
    logic [31:0] rec_rd;
    logic        rec_we;
    logic [31:0] rec_wd;

    assign rec_pc = rec_q[176:145];
    assign rec_mn = rec_q[144:65];
    assign rec_rd = rec_q[64:33];
    assign rec_we = rec_q[32];
    assign rec_wd = rec_q[31:0];

    assign push_req = enable && trace_valid;
    assign full     = (level_q == LW'(FIFO_DEPTH));
    assign empty    = (level_q == '0);
    assign push     = push_req && !full;
    assign drop     = push_req && full;
    assign pop      = (state_q == IDLE) && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {trace_pc, ascii_chain, reg_to_ascii_rd, rd_wr_en, rd_wdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
            rec_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                rec_q    <= mem[rd_ptr_q];
            end
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LW'(1);
            end
            if (drop && (drop_q != '1)) begin
                drop_q <= drop_q + DROP_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // Zero bytes in decoder strings are padding and print as blanks
    function automatic logic [7:0] pad_char(input logic [7:0] b);
        return (b == 8'h00) ? 8'h20 : b;
    endfunction

    logic [7:0] line [34];

    always_comb begin
        for (int i = 0; i < 34; i++) begin
            line[i] = 8'h20;
        end
        for (int i = 0; i < 8; i++) begin
            line[i]      = hex_char(rec_pc[28-4*i +: 4]);
            line[25 + i] = rec_we ? hex_char(rec_wd[28-4*i +: 4]) : 8'h2d;
        end
        for (int i = 0; i < 10; i++) begin
            line[9 + i] = pad_char(rec_mn[72-8*i +: 8]);
        end
        for (int i = 0; i < 4; i++) begin
            line[20 + i] = rec_we ? pad_char(rec_rd[24-8*i +: 8]) : 8'h2d;
        end
        line[8]  = 8'h20;
        line[19] = 8'h20;
        line[24] = 8'h3d;
        line[33] = 8'h0a;
    end

    assign tx_valid   = (state_q == SEND);
    assign tx_byte    = (state_q == SEND) ? line[idx_q] : 8'h00;
    assign fifo_level = level_q;
    assign drop_cnt   = drop_q;
    assign busy       = (state_q == SEND) || (level_q != '0);

endmodule

// File: tb/tb_nanorv32_trace_serializer.sv
// tb/tb_nanorv32_trace_serializer.sv - directed table-driven bench for the trace serializer
module tb_nanorv32_trace_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [79:0] ascii_chain;
    logic [31:0] reg_to_ascii_rd;
    logic        rd_wr_en;
    logic [31:0] rd_wdata;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic [2:0]  fifo_level;
    logic [1:0]  drop_cnt;
    logic        busy;

    nanorv32_trace_serializer #(.FIFO_DEPTH(4), .DROP_CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .trace_valid(trace_valid),
        .trace_pc(trace_pc), .ascii_chain(ascii_chain), .reg_to_ascii_rd(reg_to_ascii_rd),
        .rd_wr_en(rd_wr_en), .rd_wdata(rd_wdata), .tx_byte(tx_byte), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .fifo_level(fifo_level), .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  pc;
        logic [79:0]  chain;
        logic [31:0]  rd;
        logic         we;
        logic [31:0]  wd;
        logic [271:0] line;
    } vec_t;

    vec_t tab [3];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    logic [7:0] rx_q [$];
    int         rx_cyc [$];
    logic       prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0] prev_b = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Accepted-byte collector plus stall-stability checks
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                check("stall_valid_held", {63'd0, tx_valid}, 64'd1);
                check("stall_byte_held", {56'd0, tx_byte}, {56'd0, prev_b});
            end
            if (tx_valid && tx_ready) begin
                rx_q.push_back(tx_byte);
                rx_cyc.push_back(cyc);
            end
            prev_v = tx_valid;
            prev_r = tx_ready;
            prev_b = tx_byte;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i);
        trace_pc        = tab[i].pc;
        ascii_chain     = tab[i].chain;
        reg_to_ascii_rd = tab[i].rd;
        rd_wr_en        = tab[i].we;
        rd_wdata        = tab[i].wd;
        trace_valid     = 1'b1;
        step();
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check("byte_count_within_budget", 64'(rx_q.size() >= n), 64'd1);
    endtask

    task automatic check_line(input string name, input int base, input logic [271:0] exp);
        logic [271:0] got = '0;
        for (int i = 0; i < 34; i++) begin
            got = {got[263:0], (base + i < rx_q.size()) ? rx_q[base + i] : 8'h00};
        end
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        trace_valid = 1'b0;
        repeat (3) step();
        check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        check("rst_tx_byte", {56'd0, tx_byte}, 64'd0);
        check("rst_level", {61'd0, fifo_level}, 64'd0);
        check("rst_drop", {62'd0, drop_cnt}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;
        step();
        rx_q.delete();
        rx_cyc.delete();
    endtask

    initial begin
        int c0;
        int hold;
        logic tgl;
        tab[0] = '{32'h00000104, {16'h0000, "addi    "}, "a0  ", 1'b1, 32'h0000002a,
                   "00000104   addi     a0  =0000002a\n"};
        tab[1] = '{32'h80000010, "c.sw      ", "zero", 1'b0, 32'h12345678,
                   "80000010 c.sw       ----=--------\n"};
        tab[2] = '{32'hdeadbeef, {"mulhsu", 32'h0}, {"s1", 16'h0000}, 1'b1, 32'hcafe0009,
                   "deadbeef mulhsu     s1  =cafe0009\n"};
        enable = 1'b1;
        tx_ready = 1'b1;
        trace_pc = '0;
        ascii_chain = '0;
        reg_to_ascii_rd = '0;
        rd_wr_en = 1'b0;
        rd_wdata = '0;
        do_reset();

        // Single records with full-rate sink: content, latency, idle afterwards
        for (int i = 0; i < 3; i++) begin
            rx_q.delete();
            rx_cyc.delete();
            c0 = cyc;
            drive(i);
            trace_valid = 1'b0;
            wait_bytes(34, 100);
            check_line("line_single", 0, tab[i].line);
            if (rx_cyc.size() >= 34) begin
                check("first_byte_cycle", 64'(rx_cyc[0] - c0), 64'd2);
                check("last_byte_cycle", 64'(rx_cyc[33] - c0), 64'd35);
            end
            check("idle_busy", {63'd0, busy}, 64'd0);
            check("idle_tx_valid", {63'd0, tx_valid}, 64'd0);
            step();
        end

        // Backpressure: alternating ready with a 3-cycle stall at byte 9
        rx_q.delete();
        rx_cyc.delete();
        drive(2);
        trace_valid = 1'b0;
        hold = 0;
        tgl = 1'b1;
        for (int k = 0; k < 300 && rx_q.size() < 34; k++) begin
            if (rx_q.size() == 9 && hold < 3 && tx_valid) begin
                tx_ready = 1'b0;
                hold++;
            end else begin
                tgl = ~tgl;
                tx_ready = tgl;
            end
            step();
        end
        tx_ready = 1'b1;
        repeat (3) step();
        check("bp_byte_count", 64'(rx_q.size()), 64'd34);
        check_line("line_backpressure", 0, tab[2].line);

        // Overflow: 7 pushes against a stalled sink
        rx_q.delete();
        rx_cyc.delete();
        tx_ready = 1'b0;
        for (int p = 0; p < 7; p++) drive(p % 3);
        trace_valid = 1'b0;
        check("ovf_level", {61'd0, fifo_level}, 64'd4);
        check("ovf_drop", {62'd0, drop_cnt}, 64'd2);
        check("ovf_busy", {63'd0, busy}, 64'd1);
        step();
        check("ovf_tx_valid_held", {63'd0, tx_valid}, 64'd1);
        tx_ready = 1'b1;
        wait_bytes(170, 400);
        repeat (40) step();
        check("ovf_total_bytes", 64'(rx_q.size()), 64'd170);
        for (int l = 0; l < 5; l++) begin
            check_line("line_overflow", 34 * l, tab[l % 3].line);
            if (l > 0 && rx_cyc.size() >= 170)
                check("line_gap", 64'(rx_cyc[34 * l] - rx_cyc[34 * l - 1]), 64'd2);
        end
        check("ovf_drain_level", {61'd0, fifo_level}, 64'd0);

        // Saturating drop counter at width 2
        do_reset();
        tx_ready = 1'b0;
        for (int p = 0; p < 10; p++) drive(p % 3);
        check("sat_drop", {62'd0, drop_cnt}, 64'd3);
        for (int p = 0; p < 2; p++) drive(p % 3);
        trace_valid = 1'b0;
        check("sat_drop_hold", {62'd0, drop_cnt}, 64'd3);
        check("sat_level", {61'd0, fifo_level}, 64'd4);
        tx_ready = 1'b1;

        // Disabled capture is ignored
        do_reset();
        enable = 1'b0;
        drive(0);
        trace_valid = 1'b0;
        step();
        check("disabled_busy", {63'd0, busy}, 64'd0);
        enable = 1'b1;

        // Asynchronous reset mid-line
        rx_q.delete();
        rx_cyc.delete();
        drive(0);
        trace_valid = 1'b0;
        wait_bytes(15, 100);
        check("pre_reset_tx_valid", {63'd0, tx_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        check("async_rst_tx_byte", {56'd0, tx_byte}, 64'd0);
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        rx_q.delete();
        rx_cyc.delete();
        drive(2);
        trace_valid = 1'b0;
        wait_bytes(34, 100);
        repeat (10) step();
        check("post_reset_bytes", 64'(rx_q.size()), 64'd34);
        check_line("line_post_reset", 0, tab[2].line);
        check("post_reset_busy", {63'd0, busy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
